// File: rtl/lpc_pkg.sv
// lpc_pkg: register map, status bit positions, default frame length and fill FSM states
package lpc_pkg;
  localparam logic [15:0] REG_FRAME_LEN = 16'h0;
  localparam logic [15:0] REG_STATUS    = 16'h1;
  localparam logic [15:0] REG_FRAME_CNT = 16'h2;
  localparam logic [15:0] REG_DROP_CNT  = 16'h3;
  localparam int ST_READY   = 0;
  localparam int ST_OVERRUN = 1;
  localparam int ST_BANK    = 2;
  localparam int ST_HOLD    = 3;
  localparam int DEFAULT_LEN = 240;
  typedef enum logic {FILL, HOLD} state_t;
endpackage

// File: rtl/lpc_pingpong_ram.sv
// lpc_pingpong_ram: two sample banks, write into the selected bank, registered read from the other
module lpc_pingpong_ram #(
  parameter int DATA_W    = 16,
  parameter int MAX_FRAME = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [2][MAX_FRAME];
  // sample write into the fill bank
  always_ff @(posedge clk)
    if (we) mem[bank][wr_addr] <= wr_data;
  // consumer read always targets the bank not being filled
  always_ff @(posedge clk)
    rd_data <= rst ? '0 : mem[~bank][rd_addr];
endmodule

// File: rtl/lpc_frame_buffer.sv
// lpc_frame_buffer: ping-pong sample framer with register port; PREEMPH_EN stores 15/16 pre-emphasised samples
module lpc_frame_buffer
  import lpc_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int MAX_FRAME   = 256,
  parameter int ADDR_W      = 8,
  parameter int DEFAULT_LEN = lpc_pkg::DEFAULT_LEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] x,
  input  logic                     v,
  input  logic [15:0]              address,
  input  logic                     read,
  input  logic                     write,
  input  logic [15:0]              writedata,
  output logic [15:0]              readdata,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     frame_ready,
  input  logic                     frame_ack,
  output logic                     overrun
);
  localparam int LW = ADDR_W + 1;
  localparam logic [15:0] MAX16 = 16'(MAX_FRAME);
  state_t state, state_n;
  logic fill, fill_n, pend, pend_n, ready_n, overrun_n;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_n;
  logic [LW-1:0] cur_len, cur_len_n, shadow, shadow_n, len_eff;
  logic [15:0] frame_cnt, frame_cnt_n, drop_cnt, drop_cnt_n, readdata_n, status;
  logic [DATA_W-1:0] sample;
  logic ack, last, we, swap, drop, clr;
`ifdef PREEMPH_EN
  localparam logic signed [DATA_W+1:0] SMAX = (DATA_W+2)'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [DATA_W+1:0] SMIN = -SMAX - 1;
  logic signed [DATA_W-1:0] x_prev;
  logic signed [DATA_W+1:0] y;
  assign y = (DATA_W+2)'(x) - ((DATA_W+2)'(x_prev) - (DATA_W+2)'(x_prev >>> 4));
  assign sample = y > SMAX ? {1'b0, {(DATA_W-1){1'b1}}} :
                  y < SMIN ? {1'b1, {(DATA_W-1){1'b0}}} : y[DATA_W-1:0];
  // previous input follows every strobed sample, dropped ones included
  always_ff @(posedge clk)
    x_prev <= rst ? '0 : v ? x : x_prev;
`else
  assign sample = x;
`endif
  lpc_pingpong_ram #(.DATA_W(DATA_W), .MAX_FRAME(MAX_FRAME), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk), .rst(rst), .we(we), .bank(fill), .wr_addr(wr_ptr), .wr_data(sample),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );
  // fill FSM next state, frame handshake and register side effects
  always_comb begin
    ack         = frame_ack && frame_ready;
    len_eff     = wr_ptr == '0 ? shadow : cur_len;
    last        = {1'b0, wr_ptr} == len_eff - 1'b1;
    we          = state == FILL && v;
    swap        = (we && last && (!frame_ready || ack)) || (state == HOLD && ack);
    drop        = state == HOLD && v;
    clr         = write && address == REG_STATUS && writedata[ST_OVERRUN];
    state_n     = state == FILL ? (we && last && !swap ? HOLD : FILL) : (ack ? FILL : HOLD);
    fill_n      = swap ? ~fill : fill;
    wr_ptr_n    = we ? (last ? '0 : wr_ptr + 1'b1) : wr_ptr;
    cur_len_n   = we && wr_ptr == '0 ? shadow : cur_len;
    shadow_n    = write && address == REG_FRAME_LEN && writedata != '0 && writedata <= MAX16 ?
                  writedata[LW-1:0] : shadow;
    pend_n      = swap && frame_ready;
    ready_n     = pend || (swap && !frame_ready) || (frame_ready && !ack);
    overrun_n   = drop || (overrun && !clr);
    frame_cnt_n = swap ? frame_cnt + 1'b1 : frame_cnt;
    drop_cnt_n  = drop ? (drop_cnt == 16'hFFFF ? drop_cnt : drop_cnt + 1'b1) : clr ? '0 : drop_cnt;
    status              = '0;
    status[ST_READY]    = frame_ready;
    status[ST_OVERRUN]  = overrun;
    status[ST_BANK]     = fill;
    status[ST_HOLD]     = state == HOLD;
    readdata_n  = !read ? readdata :
                  address == REG_FRAME_LEN ? 16'(shadow) :
                  address == REG_STATUS    ? status :
                  address == REG_FRAME_CNT ? frame_cnt :
                  address == REG_DROP_CNT  ? drop_cnt : '0;
  end
  // state and register update
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      fill        <= 1'b0;
      pend        <= 1'b0;
      frame_ready <= 1'b0;
      overrun     <= 1'b0;
      wr_ptr      <= '0;
      cur_len     <= LW'(DEFAULT_LEN);
      shadow      <= LW'(DEFAULT_LEN);
      frame_cnt   <= '0;
      drop_cnt    <= '0;
      readdata    <= '0;
    end else begin
      state       <= state_n;
      fill        <= fill_n;
      pend        <= pend_n;
      frame_ready <= ready_n;
      overrun     <= overrun_n;
      wr_ptr      <= wr_ptr_n;
      cur_len     <= cur_len_n;
      shadow      <= shadow_n;
      frame_cnt   <= frame_cnt_n;
      drop_cnt    <= drop_cnt_n;
      readdata    <= readdata_n;
    end
  end
endmodule
